// File: rtl/serial_parallel_rx_pkg.sv
// Shared link definitions for the parallel/serial lane pair: symbol values and receiver FSM encodings.
package serial_parallel_rx_pkg;

  localparam int unsigned SP_SYM_W = 8;

  localparam logic [SP_SYM_W-1:0] SP_COM      = 8'hBC;
  localparam logic [SP_SYM_W-1:0] SP_IDLE_SYM = 8'h7C;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ACTIVE = 2'd2
  } sp_state_e;

endpackage

// File: rtl/sp_byte_assembler.sv
// Bit-serial word assembler: MSB-first shift register plus word-phase counter.
// The window w_c includes the bit currently on data_in, so a word is complete on the edge that samples it.
module sp_byte_assembler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             align,
  output logic [WIDTH-1:0] w_c,
  output logic             word_done_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-2:0] sr_q;
  logic [CNT_W-1:0] bit_cnt_q;

  assign w_c         = {sr_q, data_in};
  assign word_done_c = (bit_cnt_q == LAST_BIT);

  // Shift every cycle regardless of alignment state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= w_c[WIDTH-2:0];
    end
  end

  // align restarts the phase so the next sampled bit is bit 0 of a word.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
    end else if (align || word_done_c) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_parallel_rx.sv
// Serial lane receiver: comma alignment, lock after LOCK_COUNT aligned COMs, then word delivery.
// Optional feature macro SP_IDLE_DETECT_EN adds IDLE_OUT and strips IDLE_SYM from the data stream.
module serial_parallel_rx
  import serial_parallel_rx_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      LOCK_COUNT = 4,
  parameter logic [WIDTH-1:0] COM        = WIDTH'(SP_COM)
`ifdef SP_IDLE_DETECT_EN
  ,
  parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(SP_IDLE_SYM)
`endif
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             VALID_OUT,
  output logic             ACTIVE
`ifdef SP_IDLE_DETECT_EN
  ,
  output logic             IDLE_OUT
`endif
);

  localparam int unsigned COM_W = $clog2(LOCK_COUNT + 1);
  localparam logic [COM_W-1:0] LOCK_LAST = COM_W'(LOCK_COUNT - 1);
  localparam logic [COM_W-1:0] LOCK_FULL = COM_W'(LOCK_COUNT);

  sp_state_e        state_q, state_d;
  logic [COM_W-1:0] com_cnt_q, com_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;
`ifdef SP_IDLE_DETECT_EN
  logic             idle_q, idle_d;
`endif

  logic [WIDTH-1:0] w_c;
  logic             word_done_c;
  logic             align_c;
  logic             is_com_c;

  sp_byte_assembler #(
    .WIDTH(WIDTH)
  ) u_assembler (
    .clk        (CLK),
    .reset      (RESET),
    .data_in    (DATA_IN),
    .align      (align_c),
    .w_c        (w_c),
    .word_done_c(word_done_c)
  );

  assign is_com_c = (w_c == COM);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_SEARCH;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
`ifdef SP_IDLE_DETECT_EN
      idle_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
`ifdef SP_IDLE_DETECT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    active_d  = active_q;
    align_c   = 1'b0;
`ifdef SP_IDLE_DETECT_EN
    idle_d    = idle_q;
`endif

    unique case (state_q)
      // Bit-wise hunt: any window position may hold the comma.
      ST_SEARCH: begin
        if (is_com_c) begin
          align_c   = 1'b1;
          com_cnt_d = COM_W'(1);
          if (LOCK_COUNT == 1) begin
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ST_COUNT;
          end
        end
      end

      // Aligned: every completed word must be another comma until lock.
      ST_COUNT: begin
        if (word_done_c) begin
          if (is_com_c) begin
            if (com_cnt_q == LOCK_LAST) begin
              com_cnt_d = LOCK_FULL;
              state_d   = ST_ACTIVE;
              active_d  = 1'b1;
            end else begin
              com_cnt_d = com_cnt_q + COM_W'(1);
            end
          end else begin
            com_cnt_d = '0;
            state_d   = ST_SEARCH;
          end
        end
      end

      // Locked: commas (and idles when enabled) are stripped, everything else is delivered.
      ST_ACTIVE: begin
        if (word_done_c) begin
          if (is_com_c) begin
`ifdef SP_IDLE_DETECT_EN
            idle_d = 1'b0;
`endif
          end
`ifdef SP_IDLE_DETECT_EN
          else if (w_c == IDLE_SYM) begin
            idle_d = 1'b1;
          end
`endif
          else begin
            data_d  = w_c;
            valid_d = 1'b1;
`ifdef SP_IDLE_DETECT_EN
            idle_d  = 1'b0;
`endif
          end
        end
      end

      default: begin
        state_d   = ST_SEARCH;
        com_cnt_d = '0;
      end
    endcase
  end

  assign DATA_OUT  = data_q;
  assign VALID_OUT = valid_q;
  assign ACTIVE    = active_q;
`ifdef SP_IDLE_DETECT_EN
  assign IDLE_OUT  = idle_q;
`endif

endmodule
